// File: rtl/demuxhot.sv
// Registered one-hot demultiplexer: one valid/ready stream in, N buffered
// channels out. Zero or multi-hot selects are swallowed and counted.
module demuxhot #(
    parameter int DW = 8,
    parameter int N  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_sel,
    input  logic [DW-1:0]   in_data,
    output logic [N-1:0]    out_valid,
    input  logic [N-1:0]    out_ready,
    output logic [N*DW-1:0] out_data,
    output logic            err,
    output logic [7:0]      err_count
);

    logic [N-1:0]  r_v;
    logic [DW-1:0] r_d [N];
    logic          r_err;
    logic [7:0]    r_err_count;

    logic [N-1:0]  w_sel_m1;
    logic          w_onehot;
    logic          w_blocked;
    logic          w_accept;
    logic          w_push_ok;
    logic          w_drop;

    assign w_sel_m1 = in_sel - {{(N-1){1'b0}}, 1'b1};
    assign w_onehot = (in_sel != '0) && ((in_sel & w_sel_m1) == '0);

    // With a one-hot select this isolates the single target channel's
    // full-and-stalled condition; invalid selects never stall.
    assign w_blocked = |(in_sel & r_v & ~out_ready);
    assign in_ready  = w_onehot ? !w_blocked : 1'b1;

    assign w_accept  = in_valid && in_ready;
    assign w_push_ok = w_accept && w_onehot;
    assign w_drop    = w_accept && !w_onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v         <= '0;
            r_err       <= 1'b0;
            r_err_count <= 8'd0;
            for (int i = 0; i < N; i++) begin
                r_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_push_ok && in_sel[i]) begin
                    r_v[i] <= 1'b1;
                    r_d[i] <= in_data;
                end else if (r_v[i] && out_ready[i]) begin
                    r_v[i] <= 1'b0;
                end
            end
            if (w_drop) begin
                r_err <= 1'b1;
                if (r_err_count != 8'hFF) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_out
            assign out_data[(g+1)*DW-1 -: DW] = r_d[g];
        end
    endgenerate

    assign out_valid = r_v;
    assign err       = r_err;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_demuxhot.sv
// Testbench for demuxhot: directed table, streaming and saturation
// sequences, then randomized traffic against a behavioural model.
module tb_demuxhot;

    localparam int DW = 8;
    localparam int N  = 8;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    in_sel;
    logic [DW-1:0]   in_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic            err;
    logic [7:0]      err_count;

    demuxhot #(.DW(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    bit       mv [N];
    bit [7:0] md [N];
    bit       merr;
    int       mcnt;

    typedef struct {
        bit       rst;
        bit       valid;
        bit [7:0] sel;
        bit [7:0] data;
        bit [7:0] rdy;
        bit       e_rdy;
        bit [7:0] e_ov;
        int       ch;
        bit [7:0] e_chd;
        bit       e_err;
        bit [7:0] e_cnt;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_ready(input bit [N-1:0] sel, input bit [N-1:0] rdy);
        int t;
        if ($countones(sel) != 1) return 1'b1;
        t = $clog2(sel);
        return !mv[t] || rdy[t];
    endfunction

    function automatic bit [7:0] chan(input int i);
        return out_data[i*DW +: DW];
    endfunction

    task automatic check_model();
        bit [N-1:0] exp_v;
        for (int i = 0; i < N; i++) exp_v[i] = mv[i];
        chk("model_out_valid", out_valid, exp_v);
        for (int i = 0; i < N; i++) begin
            if (chan(i) !== md[i]) chk($sformatf("model_data_ch%0d", i), chan(i), md[i]);
        end
        chk("model_err", err, merr);
        chk("model_err_count", err_count, mcnt);
    endtask

    // One clock: drive, check in_ready, clock, advance model, check outputs.
    task automatic step(input bit r, input bit v, input bit [7:0] s,
                        input bit [7:0] d, input bit [7:0] rd, output bit got_rdy);
        bit exp_rdy;
        bit acc;
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = rd;
        #1;
        exp_rdy = model_ready(s, rd);
        got_rdy = in_ready;
        chk("model_in_ready", in_ready, exp_rdy);
        acc = v && exp_rdy;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < N; i++) begin mv[i] = 0; md[i] = 0; end
            merr = 0; mcnt = 0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (acc && $countones(s) == 1 && s[i]) begin
                    mv[i] = 1; md[i] = d;
                end else if (mv[i] && rd[i]) begin
                    mv[i] = 0;
                end
            end
            if (acc && $countones(s) != 1) begin
                merr = 1;
                if (mcnt < 255) mcnt++;
            end
        end
        #1;
        check_model();
    endtask

    initial begin
        bit          rdy_o;
        bit [7:0]    sel_r, dat_r, rd_r;
        bit          val_r, hold;

        rst = 1; in_valid = 0; in_sel = 0; in_data = 0; out_ready = 0;
        for (int i = 0; i < N; i++) begin mv[i] = 0; md[i] = 0; end
        merr = 0; mcnt = 0;

        //           rst val sel    data   rdy    erdy ov     ch dat    err cnt
        tbl.push_back('{1, 1, 8'h01, 8'h11, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0});
        tbl.push_back('{1, 1, 8'h01, 8'h11, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 0, 8'h00, 0, 0});
        tbl.push_back('{0, 1, 8'h04, 8'hA5, 8'h00, 1, 8'h04, 2, 8'hA5, 0, 0});
        tbl.push_back('{0, 1, 8'h04, 8'h5A, 8'h00, 0, 8'h04, 2, 8'hA5, 0, 0});
        tbl.push_back('{0, 1, 8'h20, 8'hC3, 8'h00, 1, 8'h24, 5, 8'hC3, 0, 0});
        tbl.push_back('{0, 0, 8'h00, 8'h00, 8'h04, 1, 8'h20, 2, 8'hA5, 0, 0});
        tbl.push_back('{0, 1, 8'h00, 8'hFF, 8'h00, 1, 8'h20, 0, 8'h00, 1, 1});
        tbl.push_back('{0, 1, 8'h05, 8'hEE, 8'h00, 1, 8'h20, 2, 8'hA5, 1, 2});
        tbl.push_back('{0, 1, 8'h20, 8'h77, 8'h20, 1, 8'h20, 5, 8'h77, 1, 2});
        tbl.push_back('{0, 1, 8'h01, 8'h12, 8'h00, 1, 8'h21, 0, 8'h12, 1, 2});
        tbl.push_back('{0, 1, 8'h80, 8'h34, 8'h00, 1, 8'hA1, 7, 8'h34, 1, 2});
        tbl.push_back('{0, 1, 8'h03, 8'h00, 8'h00, 1, 8'hA1, 7, 8'h34, 1, 3});
        tbl.push_back('{1, 1, 8'h02, 8'h99, 8'h00, 1, 8'h00, 7, 8'h00, 0, 0});
        tbl.push_back('{0, 1, 8'h01, 8'h56, 8'h00, 1, 8'h01, 0, 8'h56, 0, 0});

        @(posedge clk); #1;
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].valid, tbl[k].sel, tbl[k].data, tbl[k].rdy, rdy_o);
            chk($sformatf("tbl%0d_in_ready", k), rdy_o, tbl[k].e_rdy);
            chk($sformatf("tbl%0d_out_valid", k), out_valid, tbl[k].e_ov);
            chk($sformatf("tbl%0d_data", k), chan(tbl[k].ch), tbl[k].e_chd);
            chk($sformatf("tbl%0d_err", k), err, tbl[k].e_err);
            chk($sformatf("tbl%0d_err_count", k), err_count, tbl[k].e_cnt);
        end

        // Streaming 01..10 into channel 3 with out_ready[3] held high
        for (int b = 1; b <= 16; b++) begin
            step(0, 1, 8'h08, 8'(b), 8'h08, rdy_o);
            chk("stream_in_ready", rdy_o, 1);
            chk("stream_valid3", out_valid[3], 1);
            chk("stream_data3", chan(3), b);
        end
        step(0, 0, 8'h00, 8'h00, 8'h08, rdy_o);
        chk("stream_drain", out_valid[3], 0);

        // Saturation of the drop counter
        for (int b = 0; b < 300; b++) step(0, 1, 8'h00, 8'h00, 8'h00, rdy_o);
        chk("sat_err", err, 1);
        chk("sat_err_count", err_count, 255);
        step(0, 1, 8'h81, 8'h00, 8'h00, rdy_o);
        chk("sat_hold", err_count, 255);

        // Randomized traffic against the model
        hold = 0; sel_r = 0; dat_r = 0; val_r = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                val_r = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 7))
                    0:       sel_r = 8'($urandom);
                    1:       sel_r = 8'h00;
                    default: sel_r = 8'h01 << $urandom_range(0, 7);
                endcase
                dat_r = 8'($urandom);
            end
            rd_r = 8'($urandom);
            step($urandom_range(0, 199) == 0, val_r, sel_r, dat_r, rd_r, rdy_o);
            hold = val_r && !rdy_o && !rst;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demuxhot.md
# demuxhot

Registered one-hot demultiplexer. It steers a single valid/ready input stream to one of N output channels, chosen by a one-hot select presented with each beat. This is the distribution-side counterpart of the one-hot mux in the logic library. Each output channel has a one-entry holding register. Beats with an invalid select (zero or multi-hot) are consumed, dropped and counted.

## Interface

Parameters:
- DW, default 8, data width per channel
- N, default 8, number of output channels (N >= 2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid && in_ready
- in_sel  input  N  one-hot destination select, qualified by in_valid
- in_data  input  DW  input beat data
- out_valid  output  N  per-channel valid
- out_ready  input  N  per-channel ready
- out_data  output  N*DW  concatenated channel data; channel i at [(i+1)*DW-1 -: DW]
- err  output  1  sticky flag; set on the first dropped beat
- err_count  output  8  saturating count of dropped beats

## Operation

- Per-channel state: valid bit v[i] and data register d[i].
- Select checks: onehot = in_sel has exactly one bit set. t = index of that bit.
- in_ready is combinational:
  - if onehot: in_ready = !v[t] || out_ready[t]
  - if not onehot: in_ready = 1, so invalid beats never stall
- Accept = in_valid && in_ready.
- Channel i update, evaluated in priority order:
  - pop = v[i] && out_ready[i]; push = accept && onehot && in_sel[i]
  - push: v[i] <= 1, d[i] <= in_data. This covers the simultaneous pop+push case: valid stays high and the new data replaces the old.
  - pop only: v[i] <= 0. d[i] holds its value.
  - neither: hold.
- Invalid beat (accept && !onehot):
  - no channel is written
  - err <= 1
  - err_count <= err_count + 1, saturating at 255
- out_valid[i] = v[i]; out_data channel i = d[i], registered, with no combinational path from in_data.
- Non-valid channels continue to drive their last d[i]. Consumers must qualify with out_valid.
- Channels are independent. Backpressure on one channel never blocks beats destined for other channels.
- Reset:
  - all v[i] = 0, all d[i] = 0
  - err = 0, err_count = 0
  - any held data is discarded
- out_ready is ignored for channels with v[i] = 0.

## Timing

- Latency: a beat accepted at edge k appears with out_valid[t] = 1 from edge k onward, i.e. visible in the cycle after acceptance.
- Throughput: one beat per cycle total. A single channel sustains one beat per cycle while its out_ready is held high.
- in_ready depends combinationally on in_sel, in_valid-independent state, and out_ready. There is no combinational path from in_valid to in_ready.
- Upstream must hold in_sel/in_data stable while in_valid && !in_ready.
- err and err_count update at the edge of the offending accept and are visible the next cycle.
- rst asserted at any edge overrides every other update at that edge. During rst, in_ready still follows the combinational rule, but no beat is recorded.

## Test plan

- Reset: hold rst for 2 cycles with in_valid = 1 -> out_valid = 0, out_data = 0, err = 0, err_count = 0, and no channel loaded after release.
- Single beat: in_sel = 8'h04, in_data = 8'hA5, out_ready = 0 -> next cycle out_valid = 8'h04 and channel 2 data = A5. Then out_ready[2] = 1 for one cycle -> out_valid = 0.
- Backpressure: channel 2 full with out_ready[2] = 0 and a new beat to channel 2 -> in_ready = 0 and data stays A5. In the same state, a beat to channel 5 (in_sel = 8'h20) -> in_ready = 1 and channel 5 loads.
- Streaming: out_ready[3] = 1 constantly, beats 01..10 to in_sel = 8'h08 on consecutive cycles -> in_ready constantly 1, channel 3 presents 01..10 in order, one per cycle, with no gaps.
- Invalid selects: beats with in_sel = 8'h00 then 8'h05 -> both accepted (in_ready = 1), no out_valid change, err = 1, err_count = 2. Then 300 invalid beats -> err_count = 255.
- Reset mid-operation: channels 0 and 7 full, err_count = 3, then assert rst -> next cycle everything is zero. A fresh beat to channel 0 after release -> normal one-cycle delivery.
